// File: rtl/proc_debug_halt_sequencer.sv
// Halt/resume sequencer driving Nios II debugreq lines and waiting for debugack.
// Optional phase timeout enabled by defining PROC_DEBUG_SEQ_TIMEOUT_EN.
module proc_debug_halt_sequencer #(
  parameter int NPROC          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic [NPROC-1:0] cpu_mask,
  input  logic [NPROC-1:0] cpu_debugack,
  output logic [NPROC-1:0] cpu_debugreq,
  output logic             busy,
  output logic             all_halted,
  output logic [NPROC-1:0] halted_mask,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HALTING,
    ST_HALTED,
    ST_RESUMING
  } state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

  state_t           state_q, state_d;
  logic [NPROC-1:0] debugreq_q, debugreq_d;
  logic [NPROC-1:0] mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             all_halted_q, all_halted_d;
  logic             tmo;
  logic             halt_done;
  logic             resume_done;

`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;

  assign tmo         = (cnt_q == CNT_LAST);
  assign timeout_err = terr_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Only masked CPUs participate; unmasked acks are filtered out here.
  assign halt_done   = ((cpu_debugack & mask_q) == mask_q);
  assign resume_done = ((cpu_debugack & mask_q) == '0);

  always_comb begin
    state_d    = state_q;
    debugreq_d = debugreq_q;
    mask_d     = mask_q;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
    terr_d     = terr_q;
    cnt_d      = ((state_q == ST_HALTING) || (state_q == ST_RESUMING)) ? cnt_q + 16'd1 : cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          mask_d     = cpu_mask;
          debugreq_d = cpu_mask;
          state_d    = ST_HALTING;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
          terr_d     = 1'b0;
          cnt_d      = '0;
`endif
        end
      end
      ST_HALTING: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (halt_done) begin
          state_d = ST_HALTED;
        end else if (tmo) begin
          debugreq_d = '0;
          state_d    = ST_IDLE;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
          terr_d     = 1'b1;
`endif
        end
      end
      ST_HALTED: begin
        if (resume_req) begin
          debugreq_d = '0;
          state_d    = ST_RESUMING;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
          terr_d     = 1'b0;
          cnt_d      = '0;
`endif
        end
      end
      ST_RESUMING: begin
        if (resume_done) begin
          state_d = ST_IDLE;
        end else if (tmo) begin
          state_d = ST_IDLE;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
          terr_d  = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d       = (state_d == ST_HALTING) || (state_d == ST_RESUMING);
    all_halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      debugreq_q   <= '0;
      mask_q       <= '0;
      busy_q       <= 1'b0;
      all_halted_q <= 1'b0;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
      terr_q       <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      debugreq_q   <= debugreq_d;
      mask_q       <= mask_d;
      busy_q       <= busy_d;
      all_halted_q <= all_halted_d;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
      terr_q       <= terr_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign cpu_debugreq = debugreq_q;
  assign busy         = busy_q;
  assign all_halted   = all_halted_q;
  assign halted_mask  = mask_q;

endmodule

// File: tb/tb_proc_debug_halt_sequencer.sv
// Directed bench for proc_debug_halt_sequencer (NPROC=2, TIMEOUT_CYCLES=16).
module tb_proc_debug_halt_sequencer;

  localparam int NPROC = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             halt_req;
  logic             resume_req;
  logic [NPROC-1:0] cpu_mask;
  logic [NPROC-1:0] cpu_debugack;
  logic [NPROC-1:0] cpu_debugreq;
  logic             busy;
  logic             all_halted;
  logic [NPROC-1:0] halted_mask;
  logic             timeout_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  proc_debug_halt_sequencer #(
    .NPROC          (NPROC),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .halt_req     (halt_req),
    .resume_req   (resume_req),
    .cpu_mask     (cpu_mask),
    .cpu_debugack (cpu_debugack),
    .cpu_debugreq (cpu_debugreq),
    .busy         (busy),
    .all_halted   (all_halted),
    .halted_mask  (halted_mask),
    .timeout_err  (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic b, input logic h,
                           input logic [1:0] req, input logic [1:0] msk);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".all_halted"}, 32'(all_halted), 32'(h));
    chk({tag, ".debugreq"}, 32'(cpu_debugreq), 32'(req));
    chk({tag, ".halted_mask"}, 32'(halted_mask), 32'(msk));
  endtask

  initial begin
    reset = 1'b1; halt_req = 1'b1; resume_req = 1'b0;
    cpu_mask = 2'b11; cpu_debugack = 2'b00;
    tick();
    tick();
    chk_state("reset", 1'b0, 1'b0, 2'b00, 2'b00);
    chk("reset.terr", 32'(timeout_err), 32'd0);
    reset = 1'b0; halt_req = 1'b0;
    tick();
    chk_state("req_in_reset_dropped", 1'b0, 1'b0, 2'b00, 2'b00);

    // Full halt with staggered acks
    halt_req = 1'b1; cpu_mask = 2'b11;
    tick();
    halt_req = 1'b0; cpu_mask = 2'b00;
    chk_state("halt.accept", 1'b1, 1'b0, 2'b11, 2'b11);
    tick(); tick(); tick();
    cpu_debugack = 2'b01;
    tick(); tick();
    chk_state("halt.partial_ack", 1'b1, 1'b0, 2'b11, 2'b11);
    cpu_debugack = 2'b11;
    tick();
    chk_state("halt.done", 1'b0, 1'b1, 2'b11, 2'b11);
    chk("halt.terr", 32'(timeout_err), 32'd0);

    // halt_req in HALTED is ignored
    halt_req = 1'b1; cpu_mask = 2'b01;
    tick();
    halt_req = 1'b0;
    chk_state("halted.halt_ignored", 1'b0, 1'b1, 2'b11, 2'b11);

    // Resume: ack falls 4 cycles after acceptance -> busy for 5 cycles
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    chk_state("resume.accept", 1'b1, 1'b0, 2'b00, 2'b11);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("resume.busy_hold", 32'(busy), 32'd1);
    end
    cpu_debugack = 2'b00;
    tick();
    chk_state("resume.done", 1'b0, 1'b0, 2'b00, 2'b11);

    // Partial mask; unmasked ack must not matter
    halt_req = 1'b1; cpu_mask = 2'b01;
    tick();
    halt_req = 1'b0; cpu_mask = 2'b11;
    chk_state("mask01.accept", 1'b1, 1'b0, 2'b01, 2'b01);
    cpu_debugack = 2'b10;
    tick();
    chk_state("mask01.unmasked_ack", 1'b1, 1'b0, 2'b01, 2'b01);
    cpu_debugack = 2'b01;
    tick();
    chk_state("mask01.halted", 1'b0, 1'b1, 2'b01, 2'b01);
    resume_req = 1'b1; cpu_debugack = 2'b10;
    tick();
    resume_req = 1'b0;
    chk_state("mask01.resuming", 1'b1, 1'b0, 2'b00, 2'b01);
    tick();
    chk_state("mask01.idle", 1'b0, 1'b0, 2'b00, 2'b01);
    cpu_debugack = 2'b00;

    // Empty mask: exactly one HALTING cycle
    halt_req = 1'b1; cpu_mask = 2'b00;
    tick();
    halt_req = 1'b0;
    chk_state("mask00.halting", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    chk_state("mask00.halted", 1'b0, 1'b1, 2'b00, 2'b00);
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    chk_state("mask00.resuming", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    chk_state("mask00.idle", 1'b0, 1'b0, 2'b00, 2'b00);

    // Simultaneous requests in IDLE, resume during HALTING
    halt_req = 1'b1; resume_req = 1'b1; cpu_mask = 2'b11;
    tick();
    halt_req = 1'b0;
    chk_state("both.halt_wins", 1'b1, 1'b0, 2'b11, 2'b11);
    tick();
    resume_req = 1'b0;
    chk_state("both.resume_ignored", 1'b1, 1'b0, 2'b11, 2'b11);
    cpu_debugack = 2'b11;
    tick();
    chk_state("both.halted", 1'b0, 1'b1, 2'b11, 2'b11);
    tick();
    chk_state("both.no_queue", 1'b0, 1'b1, 2'b11, 2'b11);
    resume_req = 1'b1; cpu_debugack = 2'b00;
    tick();
    resume_req = 1'b0;
    tick();
    chk_state("both.idle", 1'b0, 1'b0, 2'b00, 2'b11);

    // Reset in cycle 2 of HALTING
    halt_req = 1'b1; cpu_mask = 2'b11;
    tick();
    halt_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_state("midreset", 1'b0, 1'b0, 2'b00, 2'b00);

    // Timeout behaviour
    halt_req = 1'b1; cpu_mask = 2'b11; cpu_debugack = 2'b00;
    tick();
    halt_req = 1'b0;
`ifdef PROC_DEBUG_SEQ_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) tick();
    chk_state("tmo.last_wait", 1'b1, 1'b0, 2'b11, 2'b11);
    tick();
    chk_state("tmo.expired", 1'b0, 1'b0, 2'b00, 2'b11);
    chk("tmo.terr_set", 32'(timeout_err), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("tmo.terr_cleared", 32'(timeout_err), 32'd0);
    for (int i = 1; i <= 15; i++) tick();
    cpu_debugack = 2'b11;
    tick();
    chk_state("tmo.completion_wins", 1'b0, 1'b1, 2'b11, 2'b11);
    chk("tmo.completion_terr", 32'(timeout_err), 32'd0);
`else
    for (int i = 1; i <= 120; i++) tick();
    chk_state("notmo.still_halting", 1'b1, 1'b0, 2'b11, 2'b11);
    chk("notmo.terr", 32'(timeout_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_debug_halt_sequencer.md
PROC_DEBUG_HALT_SEQUENCER -- requirements
Module: proc_debug_halt_sequencer

Interface
REQ-001 The block SHALL have parameter NPROC, default 2, meaning the number of Nios II CPUs sequenced.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles a halt or resume phase may wait for acknowledge (range 2..65535).
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port halt_req  input  1  meaning a one-cycle pulse requesting a halt of all masked CPUs.
REQ-006 The block SHALL have port resume_req  input  1  meaning a one-cycle pulse requesting a resume of the halted CPUs.
REQ-007 The block SHALL have port cpu_mask  input  NPROC  meaning the CPUs that take part in the sequence, sampled only when a request is accepted.
REQ-008 The block SHALL have port cpu_debugack  input  NPROC  meaning the per-CPU debugack, high while that CPU is in debug mode.
REQ-009 The block SHALL have port cpu_debugreq  output  NPROC  meaning the per-CPU registered debug request.
REQ-010 The block SHALL have port busy  output  1  meaning the block is in HALTING or RESUMING.
REQ-011 The block SHALL have port all_halted  output  1  meaning the block is in HALTED.
REQ-012 The block SHALL have port halted_mask  output  NPROC  meaning the latched mask of the current or last sequence.
REQ-013 The block SHALL have port timeout_err  output  1  meaning a sticky flag that the last phase timed out.

Function
REQ-014 The state machine SHALL have the states IDLE, HALTING, HALTED and RESUMING, and all outputs SHALL be registered.
REQ-015 In IDLE, halt_req SHALL be accepted: halted_mask<=cpu_mask, cpu_debugreq<=cpu_mask, timeout_err<=0 and state<=HALTING, all on the same edge.
REQ-016 In HALTING, the transition to HALTED SHALL occur on the first edge at which (cpu_debugack & halted_mask)==halted_mask, with at least one cycle spent in HALTING.
REQ-017 A halt accepted with cpu_mask==0 SHALL spend exactly one cycle in HALTING and then enter HALTED.
REQ-018 In HALTED, resume_req SHALL be accepted: cpu_debugreq<=0, timeout_err<=0 and state<=RESUMING.
REQ-019 In RESUMING, the transition to IDLE SHALL occur on the first edge at which (cpu_debugack & halted_mask)==0.
REQ-020 halt_req outside IDLE and resume_req outside HALTED SHALL be ignored, with no queueing.
REQ-021 When halt_req and resume_req are asserted together, only the request legal in the current state SHALL act.
REQ-022 cpu_debugreq SHALL stay constant throughout HALTING and HALTED.
REQ-023 Acknowledges from unmasked CPUs SHALL never affect any transition.
REQ-024 A timeout counter SHALL clear on entry to HALTING or RESUMING and increment each cycle spent in that state.
REQ-025 If the counter reaches TIMEOUT_CYCLES-1 in HALTING without completion, the block SHALL set cpu_debugreq<=0 and timeout_err<=1 and go to IDLE.
REQ-026 If the counter reaches TIMEOUT_CYCLES-1 in RESUMING without completion, the block SHALL set timeout_err<=1 and go to IDLE.
REQ-027 If completion and timeout occur on the same edge, completion SHALL win and timeout_err SHALL stay 0.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set state=IDLE, cpu_debugreq=0, busy=0, all_halted=0, halted_mask=0, timeout_err=0 and counter=0.
REQ-029 A reset asserted mid-sequence SHALL abort that sequence and drop cpu_debugreq on the same edge.
REQ-030 Requests presented during the cycle reset is asserted SHALL be discarded.

Configuration
REQ-031 With macro PROC_DEBUG_SEQ_TIMEOUT_EN defined, the timeout counter and timeout_err SHALL behave per REQ-024 to REQ-027.
REQ-032 Without PROC_DEBUG_SEQ_TIMEOUT_EN, no counter SHALL be built, HALTING and RESUMING SHALL wait indefinitely, and timeout_err SHALL be constant 0.

Verification
REQ-033 Scenario: NPROC=2, mask=2'b11, halt_req; debugack[0] rises 3 cycles later and debugack[1] 5 cycles later -> debugreq=2'b11 one cycle after the request, and all_halted=1 on the edge after debugack==2'b11.
REQ-034 Scenario: mask=2'b01 with debugack[1] held 0 -> HALTED is reached on debugack[0] alone, and debugreq[1] stays 0.
REQ-035 Scenario: TIMEOUT_CYCLES=16 with debugack held 0 -> IDLE is entered 16 cycles after HALTING entry, with timeout_err=1 and debugreq=0; without the macro, the block stays in HALTING for more than 100 cycles.
REQ-036 Scenario: in HALTED, resume_req is pulsed and debugack falls 4 cycles later -> busy=1 for 5 cycles, then IDLE with all_halted=0.
REQ-037 Scenario: reset is pulsed in cycle 2 of HALTING -> next cycle debugreq=0, busy=0 and halted_mask=0.
REQ-038 Scenario: halt_req and resume_req together in IDLE, and resume_req in HALTING -> the halt proceeds and the resume is ignored.
